// File: rtl/remote_bus_pkg.sv
// Shared types and constants for the remote bus arbiter.
package remote_bus_pkg;
   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // daddr[15:14] value that selects core-local memory; anything else is remote
   localparam logic [1:0] LOCAL_REGION   = 2'b00;
   localparam int         BUS_DATA_WIDTH = 16;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after start_i,
// wrapping, with one optional index masked out.
module rr_priority_picker #(
   parameter int NUM_CORES = 4,
   parameter int IDX_WIDTH = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req_i,
   input  logic [IDX_WIDTH-1:0] start_i,
   input  logic [IDX_WIDTH-1:0] mask_idx_i,
   input  logic                 mask_en_i,
   output logic                 valid_o,
   output logic [IDX_WIDTH-1:0] idx_o
);
   logic [NUM_CORES-1:0] req_m;

   always_comb begin
      req_m = req_i;
      if (mask_en_i) req_m[mask_idx_i] = 1'b0;
   end

   // Scan offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      int j;
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         j = int'(start_i) + k;
         if (j >= NUM_CORES) j = j - NUM_CORES;
         if (req_m[j]) begin
            valid_o = 1'b1;
            idx_o   = IDX_WIDTH'(j);
         end
      end
   end
endmodule

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter sharing one remote memory/IO bus between NUM_CORES
// cores, one transaction in flight, back-to-back grants without a bubble.
module remote_bus_arbiter
   import remote_bus_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int IDX_WIDTH = $clog2(NUM_CORES)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [BUS_DATA_WIDTH*NUM_CORES-1:0]   core_addr,
   input  logic [NUM_CORES-1:0]                  core_wren,
   input  logic [NUM_CORES-1:0]                  core_rden,
   input  logic [BUS_DATA_WIDTH*NUM_CORES-1:0]   core_write_val,
   output logic [NUM_CORES-1:0]                  core_ready,
   output logic [BUS_DATA_WIDTH-1:0]             core_read_val,
   output logic [BUS_DATA_WIDTH-1:0]             bus_addr,
   output logic                                  bus_wren,
   output logic                                  bus_rden,
   output logic [BUS_DATA_WIDTH-1:0]             bus_write_val,
   input  logic                                  bus_ready,
   input  logic [BUS_DATA_WIDTH-1:0]             bus_read_val
);
   arb_state_e           state_q, state_d;
   logic [IDX_WIDTH-1:0] grant_q, grant_d;
   logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

   logic [NUM_CORES-1:0] req;
   logic [IDX_WIDTH-1:0] grant_inc;
   logic [IDX_WIDTH-1:0] pick_start;
   logic                 pick_valid;
   logic [IDX_WIDTH-1:0] pick_idx;
   logic                 busy;

   assign req       = core_wren | core_rden;
   assign busy      = (state_q == ARB_BUSY);
   assign grant_inc = (grant_q == IDX_WIDTH'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;

   // In BUSY the picker pre-computes the successor of the current grant.
   assign pick_start = busy ? grant_inc : rr_ptr_q;

   rr_priority_picker #(
      .NUM_CORES (NUM_CORES),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_picker (
      .req_i      (req),
      .start_i    (pick_start),
      .mask_idx_i (grant_q),
      .mask_en_i  (busy),
      .valid_o    (pick_valid),
      .idx_o      (pick_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_BUSY;
               grant_d = pick_idx;
            end
         end
         ARB_BUSY: begin
            if (!req[grant_q]) begin
               state_d = ARB_IDLE;
            end else if (bus_ready) begin
               rr_ptr_d = grant_inc;
               if (pick_valid) grant_d = pick_idx;
               else            state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Bus side depends only on state/grant and the granted core's inputs.
   always_comb begin
      bus_addr      = '0;
      bus_wren      = 1'b0;
      bus_rden      = 1'b0;
      bus_write_val = '0;
      core_ready    = '0;
      if (busy) begin
         bus_addr            = core_addr[BUS_DATA_WIDTH*int'(grant_q) +: BUS_DATA_WIDTH];
         bus_write_val       = core_write_val[BUS_DATA_WIDTH*int'(grant_q) +: BUS_DATA_WIDTH];
         bus_wren            = core_wren[grant_q];
         bus_rden            = core_rden[grant_q];
         core_ready[grant_q] = bus_ready;
      end
   end

   // Cores sample read data the cycle after their ready, so no grant gating.
   assign core_read_val = bus_read_val;
endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Directed plus randomized checks of remote_bus_arbiter against a
// transaction-level round-robin model.
module tb_remote_bus_arbiter;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [16*N-1:0] core_addr, core_write_val;
   logic [N-1:0]    wr, rd, core_ready;
   logic [15:0]     core_read_val, bus_addr, bus_write_val, bus_read_val;
   logic            bus_wren, bus_rden, bus_ready;
   logic [15:0]     addr_r [N];
   logic [15:0]     wd [N];

   int total = 0;
   int bad   = 0;

   // model: is a transaction in flight, who owns it, where the next search starts
   bit          m_busy;
   int          m_g, m_p;
   logic [N-1:0] rdy_cap;

   remote_bus_arbiter #(.NUM_CORES(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .core_addr      (core_addr),
      .core_wren      (wr),
      .core_rden      (rd),
      .core_write_val (core_write_val),
      .core_ready     (core_ready),
      .core_read_val  (core_read_val),
      .bus_addr       (bus_addr),
      .bus_wren       (bus_wren),
      .bus_rden       (bus_rden),
      .bus_write_val  (bus_write_val),
      .bus_ready      (bus_ready),
      .bus_read_val   (bus_read_val)
   );

   always #5 clk = ~clk;

   always_comb begin
      core_addr      = '0;
      core_write_val = '0;
      for (int i = 0; i < N; i++) begin
         core_addr[16*i +: 16]      = addr_r[i];
         core_write_val[16*i +: 16] = wd[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   // first requesting core at or after 'from' (wrapping), ignoring 'skip'
   function automatic int pick(input logic [N-1:0] r, input int from, input int skip);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (from + k) % N;
         if (r[j] && j != skip) return j;
      end
      return -1;
   endfunction

   task automatic chk_cyc();
      logic [15:0] ea, ev;
      logic        ew, er;
      logic [N-1:0] ecr;
      @(negedge clk);
      ea = '0; ev = '0; ew = 1'b0; er = 1'b0; ecr = '0;
      if (m_busy) begin
         ea = addr_r[m_g];
         ev = wd[m_g];
         ew = wr[m_g];
         er = rd[m_g];
         ecr[m_g] = bus_ready;
      end
      chk("bus_addr", 32'(bus_addr), 32'(ea));
      chk("bus_wval", 32'(bus_write_val), 32'(ev));
      chk("bus_wren", 32'(bus_wren), 32'(ew));
      chk("bus_rden", 32'(bus_rden), 32'(er));
      chk("core_ready", 32'(core_ready), 32'(ecr));
      chk("rdval", 32'(core_read_val), 32'(bus_read_val));
      rdy_cap = core_ready;
   endtask

   task automatic tick();
      logic [N-1:0] r;
      logic         br;
      int           w;
      r  = wr | rd;
      br = bus_ready;
      @(posedge clk);
      if (reset) begin
         m_busy = 1'b0; m_g = 0; m_p = 0;
      end else if (!m_busy) begin
         w = pick(r, m_p, -1);
         if (w >= 0) begin m_busy = 1'b1; m_g = w; end
      end else if (!r[m_g]) begin
         m_busy = 1'b0;
      end else if (br) begin
         m_p = (m_g + 1) % N;
         w = pick(r, m_p, m_g);
         if (w >= 0) m_g = w;
         else        m_busy = 1'b0;
      end
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin chk_cyc(); tick(); end
   endtask

   task automatic drive_rand();
      for (int i = 0; i < N; i++) begin
         if ((wr[i] | rd[i]) && (rdy_cap[i] || $urandom_range(0, 19) == 0)) begin
            wr[i] = 1'b0; rd[i] = 1'b0;
         end
         if (!(wr[i] | rd[i]) && $urandom_range(0, 2) == 0) begin
            addr_r[i] = {2'($urandom_range(1, 3)), 14'($urandom)};
            wd[i]     = 16'($urandom);
            if ($urandom_range(0, 1) == 1) wr[i] = 1'b1;
            else                           rd[i] = 1'b1;
         end
      end
      bus_ready    = ($urandom_range(0, 3) != 0);
      bus_read_val = 16'($urandom);
   endtask

   initial begin
      reset = 1'b1; wr = '0; rd = '0; bus_ready = 1'b0; bus_read_val = '0;
      for (int i = 0; i < N; i++) begin addr_r[i] = 16'h4000 + 16'(i); wd[i] = '0; end
      m_busy = 1'b0; m_g = 0; m_p = 0; rdy_cap = '0;

      // reset state
      chk_cyc();
      tick();
      reset = 1'b0;
      run(1);

      // single zero-wait read from core 2
      rd[2] = 1'b1; addr_r[2] = 16'h4010;
      run(1);
      bus_ready = 1'b1;
      chk_cyc();
      chk("rd_strobe", 32'(bus_rden), 32'd1);
      chk("rd_addr", 32'(bus_addr), 32'h4010);
      chk("rd_ready", 32'(core_ready), 32'b0100);
      tick();
      rd[2] = 1'b0; bus_ready = 1'b0; bus_read_val = 16'hBEEF;
      chk_cyc();
      chk("rd_data", 32'(core_read_val), 32'hBEEF);
      chk("rd_idle", 32'(bus_rden), 32'd0);
      tick();

      // write from core 0 with three wait states
      wr[0] = 1'b1; addr_r[0] = 16'h8000; wd[0] = 16'h1234;
      run(1);
      for (int k = 0; k < 4; k++) begin
         bus_ready = (k == 3);
         chk_cyc();
         chk("ws_wren", 32'(bus_wren), 32'd1);
         chk("ws_addr", 32'(bus_addr), 32'h8000);
         chk("ws_wval", 32'(bus_write_val), 32'h1234);
         chk("ws_ready", 32'(core_ready), (k == 3) ? 32'd1 : 32'd0);
         tick();
      end
      wr[0] = 1'b0; bus_ready = 1'b0;
      run(1);

      // all four requesting on a zero-wait bus; core 0 was served last
      for (int i = 0; i < N; i++) addr_r[i] = 16'hC000 + 16'(i);
      rd = '1; bus_ready = 1'b1;
      run(1);
      for (int k = 0; k < 12; k++) begin
         chk_cyc();
         chk("rr_ready", 32'(core_ready), 32'(1 << ((1 + k) % N)));
         tick();
      end
      rd = '0;
      run(2);

      // lone core 1 requesting back-to-back
      rd[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk_cyc();
         chk("lone_ready", 32'(core_ready), (k % 2 == 1) ? 32'b0010 : 32'd0);
         tick();
      end
      rd[1] = 1'b0; bus_ready = 1'b0;
      run(1);

      // core 3 drops its read while waiting; pointer must stay at 2
      rd[3] = 1'b1;
      run(1);
      chk_cyc();
      chk("drop_busy", 32'(bus_rden), 32'd1);
      tick();
      rd[3] = 1'b0;
      chk_cyc();
      chk("drop_strobe", 32'(bus_rden), 32'd0);
      tick();
      run(1);
      rd = '1; bus_ready = 1'b1;
      run(1);
      chk_cyc();
      chk("drop_ptr", 32'(core_ready), 32'b0100);
      tick();
      rd = '0; bus_ready = 1'b0;
      run(2);

      // reset in the middle of a core 1 write
      wr[1] = 1'b1; addr_r[1] = 16'hC002;
      run(1);
      chk_cyc();
      chk("rst_pre", 32'(bus_wren), 32'd1);
      rd[0] = 1'b1;
      reset = 1'b1;
      #1;
      chk("rst_wren", 32'(bus_wren), 32'd0);
      chk("rst_rden", 32'(bus_rden), 32'd0);
      chk("rst_ready", 32'(core_ready), 32'd0);
      chk("rst_addr", 32'(bus_addr), 32'd0);
      tick();
      reset = 1'b0; bus_ready = 1'b1;
      run(1);
      chk_cyc();
      chk("rst_first", 32'(core_ready), 32'b0001);
      tick();
      drive_rand();

      // randomized traffic
      repeat (400) begin
         chk_cyc();
         tick();
         drive_rand();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/remote_bus_arbiter.md
Name: remote_bus_arbiter

Overview:
- Shares one remote (non-local, daddr[15:14] != 0) memory/device bus between NUM_CORES processor cores.
- Each core's remote port (addr, wren, rden, ready, write_val, read_val) connects to one requester slot; one shared port drives the global memory/IO fabric.
- Round-robin arbitration, one transaction in flight at a time.
- Non-granted cores see ready=0 and therefore stall.

Parameters:
- NUM_CORES, 4, number of requester slots (2..16).
- IDX_WIDTH, $clog2(NUM_CORES), width of the grant index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- core_addr  in  16*NUM_CORES  per-core address; slot i = bits [16*i+15:16*i].
- core_wren  in  NUM_CORES  per-core write request.
- core_rden  in  NUM_CORES  per-core read request.
- core_write_val  in  16*NUM_CORES  per-core write data, packed like core_addr.
- core_ready  out  NUM_CORES  per-core completion strobe.
- core_read_val  out  16  read data, broadcast to all cores.
- bus_addr  out  16  shared bus address.
- bus_wren  out  1  shared bus write strobe.
- bus_rden  out  1  shared bus read strobe.
- bus_write_val  out  16  shared bus write data.
- bus_ready  in  1  shared bus completion, combinational from the target.
- bus_read_val  in  16  shared bus read data; valid the cycle after bus_ready.

Behaviour:
- Request: req[i] = core_wren[i] | core_rden[i]. A core holds addr/data/strobes stable until it sees core_ready[i]=1. Asserting wren and rden together is illegal; behaviour is undefined.
- States: IDLE and BUSY. Registers: state, grant (IDX_WIDTH bits), rr_ptr (IDX_WIDTH bits).
- Reset (async): state=IDLE, grant=0, rr_ptr=0. All outputs are 0 while reset is asserted and in IDLE.
- IDLE:
  - Bus outputs are 0 and core_ready is all 0.
  - If any req is set, pick the first set bit searching upward from rr_ptr with wrap-around.
  - At the next edge: grant<=winner, state<=BUSY.
  - Arbitration latency: one cycle from request to bus strobe.
- BUSY:
  - bus_addr, bus_write_val, bus_wren, bus_rden are muxed combinationally from slot grant.
  - core_ready[grant] = bus_ready; all other core_ready bits are 0.
- Completion (BUSY and bus_ready=1):
  - rr_ptr <= grant+1, wrapping at NUM_CORES.
  - Choose the next winner from req with bit grant masked, searching from grant+1.
  - If a winner exists: grant<=winner and stay in BUSY (back-to-back, no idle bubble). Otherwise go to IDLE.
  - The just-served core is therefore never regranted on the immediately following cycle. If it is the only requester, one IDLE cycle separates its transactions.
- Wait states: BUSY with bus_ready=0 holds all bus outputs stable. No timeout.
- Dropped request: if req[grant] deasserts in BUSY without bus_ready, go to IDLE next cycle. bus strobes follow the requester combinationally (drop immediately). rr_ptr is unchanged.
- Read data:
  - core_read_val = bus_read_val, unregistered pass-through.
  - The core samples it the cycle after its ready, so the broadcast is safe even when the grant has already moved on.
  - The arbiter must not gate core_read_val with grant.
- Reset mid-transaction: the transaction is abandoned, strobes drop asynchronously, and the state returns to IDLE.
- Fairness: with N cores requesting continuously, each is served exactly once every N transactions.
- No combinational path from bus_ready to any bus_* output.

Decomposition:
- Package remote_bus_pkg:
  - state encoding (ARB_IDLE, ARB_BUSY);
  - region constants LOCAL_REGION=2'b00 (daddr[15:14]) and BUS_DATA_WIDTH=16.
- One sub-module, rr_priority_picker:
  - inputs: req vector, start index, mask index plus mask enable;
  - outputs: valid, index;
  - purely combinational;
  - instanced once and used for both the IDLE and completion decisions.

Test Plan:
- Single read, zero-wait: core 2 rden, addr 16'h4010. Required response:
  - bus_rden=1 and bus_addr=16'h4010 one cycle later;
  - with bus_ready=1 there, core_ready=4'b0100 that cycle;
  - bus_read_val=16'hBEEF next cycle appears on core_read_val;
  - state returns to IDLE.
- Wait states: core 0 writes 16'h1234 to 16'h8000 and bus_ready is held 0 for 3 cycles. Required response:
  - bus_wren, bus_addr and bus_write_val stay stable for 4 BUSY cycles;
  - core_ready[0] pulses only in the 4th.
- Round-robin: cores 0-3 all request continuously with a zero-wait bus. Required response:
  - grant order 0,1,2,3,0,…;
  - no IDLE cycle between transactions;
  - each core_ready bit asserts once every 4 cycles.
- Lone repeat requester: core 1 requests back-to-back. Required response: BUSY, IDLE, BUSY alternation, with core_ready[1] every 2 cycles.
- Dropped request / reset: core 3 is granted and its rden drops with bus_ready=0. Required response: IDLE next cycle and rr_ptr unchanged. Then, with core 1 mid-transaction, assert reset. Required response: all bus strobes and core_ready=0 immediately, and after release the first grant goes to core 0 if it is requesting.
